// File: rtl/vga_timing_pkg.sv
// Default horizontal timing, sync latency and FSM state type
// shared by the sync timing decoder and its sub-modules.
package vga_timing_pkg;

    localparam int DEF_HPIXEL        = 640;
    localparam int DEF_H_FRONT_PORCH = 16;
    localparam int DEF_H_SYNC_PULSE  = 96;
    localparam int DEF_H_BACK_PORCH  = 48;
    localparam int DEF_H_TOL         = 2;
    localparam int DEF_LOCK_LINES    = 4;

    // pin edge to detected-edge pulse, in clocks
    localparam int SYNC_LAT = 3;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } sync_state_t;

    function automatic logic in_window(
        input logic [10:0] val,
        input int          nom,
        input int          tol
    );
        return (int'(val) >= nom - tol) &&
               (int'(val) <= nom + tol);
    endfunction

endpackage

// File: rtl/sync_timing_decoder_if.sv
// Regenerated-timing output bundle of the sync timing decoder.
// master drives the bundle, slave observes it.
interface sync_timing_decoder_if;

    logic [9:0]  h_count;
    logic        locked;
    logic        polarity;
    logic        line_strobe;
    logic [10:0] period;
    logic [7:0]  err_count;

    modport master (
        output h_count, locked, polarity,
        output line_strobe, period, err_count
    );

    modport slave (
        input h_count, locked, polarity,
        input line_strobe, period, err_count
    );

endinterface

// File: rtl/sync_edge_detector.sv
// Two-flop synchronizer plus registered edge detector.
// Rise/fall pulses appear three clocks after the pin edge.
module sync_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // synchronize the pin, then register level and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            prev_q <= sync_q[1];
            level  <= sync_q[1];
            rise   <= sync_q[1] & ~prev_q;
            fall   <= ~sync_q[1] & prev_q;
        end
    end

endmodule

// File: rtl/sync_timing_decoder.sv
// Horizontal sync decoder: detects polarity, locks to the line
// timing and regenerates a pixel counter. SYNC_DECODER_STATS_EN
// enables the lock-loss counter on o_err_count.
module sync_timing_decoder
    import vga_timing_pkg::*;
#(
    parameter int HPIXEL        = DEF_HPIXEL,
    parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
    parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int H_TOL         = DEF_H_TOL,
    parameter int LOCK_LINES    = DEF_LOCK_LINES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hsync,
    output logic [9:0]  o_hCount,
    output logic        o_locked,
    output logic        o_polarity,
    output logic        o_line_strobe,
    output logic [10:0] o_period,
    output logic [7:0]  o_err_count
);

    localparam int H_TOTAL = HPIXEL + H_FRONT_PORCH +
                             H_SYNC_PULSE + H_BACK_PORCH;
    localparam int TIMEOUT = H_TOTAL + H_TOL;
    localparam logic [9:0] HC_LOAD =
        10'(HPIXEL + H_FRONT_PORCH + SYNC_LAT);
    localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    sync_timing_decoder_if tim ();

    sync_state_t state_q, state_d;
    logic        lvl, rise, fall;
    logic        lead, trail, edge_any;
    logic        search_hit, line_good, timeout, lock_hit;
    logic [10:0] phase_q, per_q, pulse_q, period_q;
    logic [7:0]  good_q;
    logic [9:0]  hc_q;
    logic        pol_q;

    sync_edge_detector u_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_hsync),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_any   = rise | fall;
    assign lead       = pol_q ? rise : fall;
    assign trail      = pol_q ? fall : rise;
    assign search_hit = edge_any &&
                        in_window(phase_q, H_SYNC_PULSE, H_TOL);
    assign line_good  = in_window(per_q, H_TOTAL, H_TOL) &&
                        in_window(pulse_q, H_SYNC_PULSE, H_TOL);
    assign timeout    = int'(phase_q) > TIMEOUT;
    assign lock_hit   = lead && line_good &&
                        (int'(good_q) + 1 >= LOCK_LINES);

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= SEARCH;
        else          state_q <= state_d;
    end

    // next state: acquire, qualify lines, drop on bad line/timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (search_hit) state_d = MEASURE;
            MEASURE: begin
                if (timeout)       state_d = SEARCH;
                else if (lock_hit) state_d = LOCKED;
            end
            LOCKED: begin
                if (timeout || (lead && !line_good))
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    // outputs decoded from state and datapath registers
    always_comb begin
        tim.locked      = (state_q == LOCKED);
        tim.line_strobe = (state_q == LOCKED) && (hc_q == '0);
        tim.h_count     = hc_q;
        tim.polarity    = pol_q;
        tim.period      = period_q;
    end

    // phase/period/pulse measurement and pixel counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q  <= '0;
            per_q    <= '0;
            pulse_q  <= '0;
            period_q <= '0;
            good_q   <= '0;
            hc_q     <= '0;
            pol_q    <= 1'b0;
        end else begin
            if (edge_any)              phase_q <= 11'd1;
            else if (phase_q != CNT_MAX) phase_q <= phase_q + 11'd1;

            // on acquisition the pulse just ended started the period
            if (state_q == SEARCH && search_hit)
                per_q <= phase_q + 11'd1;
            else if (lead)
                per_q <= 11'd1;
            else if (per_q != CNT_MAX)
                per_q <= per_q + 11'd1;

            if (state_q == SEARCH) begin
                if (search_hit) begin
                    pulse_q <= phase_q;
                    pol_q   <= ~lvl;
                end
            end else if (trail) begin
                pulse_q <= phase_q;
            end

            if (state_q != SEARCH && lead)
                period_q <= per_q;

            if (state_d == SEARCH)
                good_q <= '0;
            else if (state_q == MEASURE && lead)
                good_q <= line_good ? good_q + 8'd1 : '0;

            if (state_d == SEARCH)
                hc_q <= '0;
            else if (state_q != SEARCH && lead)
                hc_q <= HC_LOAD;
            else if (hc_q == HC_LAST)
                hc_q <= '0;
            else
                hc_q <= hc_q + 10'd1;
        end
    end

`ifdef SYNC_DECODER_STATS_EN
    logic [7:0] err_q;

    // count lock losses, saturating
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            err_q <= '0;
        else if (state_q == LOCKED && state_d == SEARCH &&
                 err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end

    assign tim.err_count = err_q;
`else
    assign tim.err_count = '0;
`endif

    assign o_hCount      = tim.h_count;
    assign o_locked      = tim.locked;
    assign o_polarity    = tim.polarity;
    assign o_line_strobe = tim.line_strobe;
    assign o_period      = tim.period;
    assign o_err_count   = tim.err_count;

endmodule

// File: tb/tb_sync_timing_decoder.sv
// Directed bench for sync_timing_decoder with a cycle-stamped
// scoreboard; honours SYNC_DECODER_STATS_EN for o_err_count.
module tb_sync_timing_decoder;

`ifdef SYNC_DECODER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    localparam int K_HC  = 0;
    localparam int K_LK  = 1;
    localparam int K_STB = 2;
    localparam int K_PER = 3;
    localparam int K_ERR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hsync = 1'b1;

    sync_timing_decoder_if mon ();

    sync_timing_decoder dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_hsync       (hsync),
        .o_hCount      (mon.h_count),
        .o_locked      (mon.locked),
        .o_polarity    (mon.polarity),
        .o_line_strobe (mon.line_strobe),
        .o_period      (mon.period),
        .o_err_count   (mon.err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    due;
        int    kind;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int kind);
        case (kind)
            K_HC:    return 32'(mon.h_count);
            K_LK:    return 32'(mon.locked);
            K_STB:   return 32'(mon.line_strobe);
            K_PER:   return 32'(mon.period);
            K_ERR:   return 32'(mon.err_count);
            default: return '1;
        endcase
    endfunction

    task automatic expect_at(input int off, input int kind,
                             input int val, input string tag);
        exp_t e;
        e.due  = cyc + off;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < sb.size();) begin
            if (sb[i].due <= cyc) begin
                chk(sb[i].tag, probe(sb[i].kind), 32'(sb[i].val));
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic send_line(input logic pol, input int per,
                             input int pw);
        hsync = pol;
        repeat (pw) tick();
        hsync = ~pol;
        repeat (per - pw) tick();
    endtask

    // leading edge seen in MEASURE/LOCKED: 659 load, then wrap
    task automatic exp_lead(input int lk, input string tag);
        expect_at(4,   K_LK,  lk,  {tag, "_lock"});
        expect_at(4,   K_HC,  659, {tag, "_hc_load"});
        expect_at(5,   K_HC,  660, {tag, "_hc_inc"});
        expect_at(145, K_HC,  0,   {tag, "_hc_wrap"});
        expect_at(145, K_STB, lk,  {tag, "_strobe"});
    endtask

    task automatic exp_lock_edge(input string tag);
        expect_at(3, K_LK, 0, {tag, "_prelock"});
        exp_lead(1, tag);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_hc",     32'(mon.h_count),     0);
        chk("rst_locked", 32'(mon.locked),      0);
        chk("rst_pol",    32'(mon.polarity),    0);
        chk("rst_strobe", 32'(mon.line_strobe), 0);
        chk("rst_period", 32'(mon.period),      0);
        chk("rst_err",    32'(mon.err_count),   0);
        rst_n = 1'b1;
        repeat (50) tick();
        chk("idle_hc", 32'(mon.h_count), 0);

        // active-low 800/96: acquire, lock on 4th good edge
        send_line(1'b0, 800, 96);
        exp_lead(0, "al_l2");
        send_line(1'b0, 800, 96);
        exp_lead(0, "al_l3");
        send_line(1'b0, 800, 96);
        exp_lead(0, "al_l4");
        send_line(1'b0, 800, 96);
        exp_lock_edge("al_l5");
        send_line(1'b0, 800, 96);
        exp_lead(1, "al_l6");
        send_line(1'b0, 800, 96);
        chk("al_pol",    32'(mon.polarity),  0);
        chk("al_period", 32'(mon.period),    800);
        chk("al_err",    32'(mon.err_count), 0);

        // one 810 line drops lock at the following edge
        exp_lead(1, "p810_own");
        send_line(1'b0, 810, 96);
        expect_at(3, K_LK,  1,     "p810_before");
        expect_at(4, K_LK,  0,     "p810_drop");
        expect_at(4, K_HC,  0,     "p810_hc");
        expect_at(4, K_PER, 810,   "p810_period");
        expect_at(4, K_ERR, STATS, "p810_err");
        send_line(1'b0, 800, 96);

        // relock, then hold sync inactive until timeout
        exp_lead(0, "rl_l1");
        send_line(1'b0, 800, 96);
        exp_lead(0, "rl_l2");
        send_line(1'b0, 800, 96);
        exp_lead(0, "rl_l3");
        send_line(1'b0, 800, 96);
        exp_lock_edge("rl_l4");
        expect_at(902, K_LK,  1,         "to_before");
        expect_at(902, K_HC,  757,       "to_hc_before");
        expect_at(903, K_LK,  0,         "to_drop");
        expect_at(903, K_HC,  0,         "to_hc");
        expect_at(903, K_ERR, 2 * STATS, "to_err");
        send_line(1'b0, 800, 96);
        repeat (300) tick();
        chk("to_locked_end", 32'(mon.locked), 0);

        // active-high 800/96
        hsync = 1'b0;
        repeat (704) tick();
        send_line(1'b1, 800, 96);
        exp_lead(0, "ah_l2");
        send_line(1'b1, 800, 96);
        exp_lead(0, "ah_l3");
        send_line(1'b1, 800, 96);
        exp_lead(0, "ah_l4");
        send_line(1'b1, 800, 96);
        exp_lock_edge("ah_l5");
        send_line(1'b1, 800, 96);
        exp_lead(1, "ah_l6");
        send_line(1'b1, 800, 96);
        chk("ah_pol",    32'(mon.polarity),  1);
        chk("ah_period", 32'(mon.period),    800);
        chk("ah_err",    32'(mon.err_count), 2 * STATS);

        // asynchronous reset mid-line while locked
        hsync = 1'b1;
        repeat (96) tick();
        hsync = 1'b0;
        repeat (200) tick();
        chk("mr_locked_pre", 32'(mon.locked), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mr_hc",     32'(mon.h_count),     0);
        chk("mr_locked", 32'(mon.locked),      0);
        chk("mr_pol",    32'(mon.polarity),    0);
        chk("mr_strobe", 32'(mon.line_strobe), 0);
        chk("mr_period", 32'(mon.period),      0);
        chk("mr_err",    32'(mon.err_count),   0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (500) tick();
        chk("mr_hc_idle", 32'(mon.h_count), 0);

        // tolerance edge 802/94 locks after full reacquisition
        send_line(1'b1, 802, 94);
        exp_lead(0, "t802_l2");
        send_line(1'b1, 802, 94);
        exp_lead(0, "t802_l3");
        send_line(1'b1, 802, 94);
        exp_lead(0, "t802_l4");
        send_line(1'b1, 802, 94);
        exp_lock_edge("t802_l5");
        expect_at(4, K_PER, 802, "t802_period");
        send_line(1'b1, 802, 94);

        // period 803 never locks
        exp_lead(1, "t803_l1");
        send_line(1'b1, 803, 96);
        expect_at(4, K_LK,  0,     "t803_drop");
        expect_at(4, K_HC,  0,     "t803_hc");
        expect_at(4, K_ERR, STATS, "t803_err");
        send_line(1'b1, 803, 96);
        for (int n = 0; n < 5; n++) begin
            exp_lead(0, "t803_meas");
            expect_at(4, K_PER, 803, "t803_period");
            send_line(1'b1, 803, 96);
        end
        chk("t803_locked_end", 32'(mon.locked), 0);

        if (sb.size() != 0) begin
            chk("sb_drained", 32'(sb.size()), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_timing_decoder.md
SYNC_TIMING_DECODER -- requirements
Module: sync_timing_decoder

Interface
REQ-001 SHALL have parameter HPIXEL, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16, clocks from active end to sync start.
REQ-003 SHALL have parameter H_SYNC_PULSE, default 96, nominal sync pulse width in clocks.
REQ-004 SHALL have parameter H_BACK_PORCH, default 48; H_TOTAL = sum of the four parameters (800).
REQ-005 SHALL have parameter H_TOL, default 2, permitted +/- clock deviation on period and pulse width.
REQ-006 SHALL have parameter LOCK_LINES, default 4, consecutive good lines required for lock.
REQ-007 SHALL have port i_clk, input, 1, pixel clock; the only clock.
REQ-008 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_hsync, input, 1, asynchronous external horizontal sync of unknown polarity.
REQ-010 SHALL have port o_hCount, output, 10, regenerated pixel counter 0..H_TOTAL-1.
REQ-011 SHALL have port o_locked, output, 1, high while timing matches the parameters.
REQ-012 SHALL have port o_polarity, output, 1, detected pulse level (0 = active-low sync).
REQ-013 SHALL have port o_line_strobe, output, 1, one-clock pulse at each regenerated line start (o_hCount wraps to 0).
REQ-014 SHALL have port o_period, output, 11, last measured leading-edge-to-leading-edge period in clocks.
REQ-015 SHALL have port o_err_count, output, 8, lock-loss counter (see Configuration).

Function
REQ-016 SHALL pass i_hsync through a 2-flop synchronizer and then a registered edge detector; total SYNC_LAT = 3 clocks from pin edge to the detected edge.
REQ-017 SHALL measure the duration of every high and low phase with an 11-bit counter that saturates at 2047.
REQ-018 SHALL use states SEARCH, MEASURE, LOCKED; reset enters SEARCH.
REQ-019 SEARCH: on each detected edge, if the just-ended phase lasted H_SYNC_PULSE +/- H_TOL, set o_polarity to that phase's level and go to MEASURE.
REQ-020 MEASURE: on each leading edge (transition into the o_polarity level), capture the period into o_period; count the line good if both the period is H_TOTAL +/- H_TOL and the last pulse is H_SYNC_PULSE +/- H_TOL; otherwise clear the good count.
REQ-021 MEASURE SHALL go to LOCKED when the good count reaches LOCK_LINES; o_locked rises in the same clock.
REQ-022 LOCKED: one bad line, or a phase counter exceeding H_TOTAL+H_TOL with no edge (timeout), SHALL return to SEARCH, drop o_locked, and clear the good count.
REQ-023 A timeout in MEASURE SHALL return to SEARCH.
REQ-024 On every detected leading edge in MEASURE or LOCKED, o_hCount SHALL load HPIXEL+H_FRONT_PORCH+SYNC_LAT (659); otherwise it increments, wrapping H_TOTAL-1 to 0.
REQ-025 o_line_strobe SHALL be high exactly in clocks where o_hCount is 0, and only while o_locked.
REQ-026 In SEARCH, o_hCount SHALL hold 0.
REQ-027 A leading edge that coincides with a natural wrap SHALL take the load value (load beats increment).

Reset
REQ-028 Assertion of i_rst_n low SHALL immediately clear o_hCount, o_locked, o_polarity, o_line_strobe, o_period, synchronizer flops, and counters, with the FSM in SEARCH.
REQ-029 o_err_count SHALL reset to 0.
REQ-030 Reset mid-line SHALL discard partial measurements; reacquisition needs a full SEARCH plus LOCK_LINES lines.

Configuration
REQ-031 With SYNC_DECODER_STATS_EN defined, o_err_count SHALL increment by 1 on each LOCKED-to-SEARCH transition and saturate at 255.
REQ-032 Without SYNC_DECODER_STATS_EN, o_err_count SHALL be driven constant 0 and no counter logic is built.

Structure
REQ-033 Package vga_timing_pkg SHALL hold the default timing constants, SYNC_LAT, and the state enum type.
REQ-034 The synchronizer and edge detector SHALL be the sub-module sync_edge_detector (outputs: synced level, rise pulse, fall pulse).

Verification
REQ-035 Active-low 800/96 sync, 6 lines -> polarity 0, locked after the 4th good leading edge following SEARCH exit, o_period = 800.
REQ-036 Active-high 800/96 sync -> o_polarity = 1, lock achieved; o_hCount = 659 the clock after each detected leading edge.
REQ-037 Locked, then one line with period 810 -> o_locked falls at that edge, o_err_count = 1 (macro on) or 0 (macro off).
REQ-038 Locked, then i_hsync held high for 1000 clocks -> o_locked drops when the phase counter passes 802.
REQ-039 Period 802 / pulse 94 (edge of tolerance) -> lock; period 803 -> never locks.
REQ-040 i_rst_n pulsed low mid-line while locked -> all outputs 0 asynchronously; relock after SEARCH plus 4 lines.
